// File: rtl/frame_uart_packer.sv
// Buffers framed pixel bytes in a 9-bit FIFO and meters them to a UART TX via tx_start/tx_finish.
// Define FRAME_CRC_EN to append a CRC-8 (poly 0x07) of each frame's pixels after its EOF.
module frame_uart_packer #(
  parameter int unsigned DEPTH_LOG2 = 9,
  parameter logic [7:0]  SYNC0      = 8'hFF,
  parameter logic [7:0]  SYNC1      = 8'h00,
  parameter logic [7:0]  SYNC2      = 8'hA5
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  frame_end,
  input  logic                  pix_valid,
  input  logic [7:0]            pix_data,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  input  logic                  tx_finish,
  output logic                  overflow,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  busy
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam int unsigned CntW  = DEPTH_LOG2 + 2;

  typedef enum logic [3:0] {
    StIdle,
    StPop,
    StHdr0,
    StHdr1,
    StHdr2,
    StSend,
    StWaitAck,
    StWaitDone
`ifdef FRAME_CRC_EN
    ,
    StCrc
`endif
  } state_e;

  state_e                state_q;
  state_e                nxt_q;
  state_e                follow;
  logic [8:0]            head_q;
  logic [7:0]            byte_sel;

  logic [8:0]            mem [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   level_q;
  logic [DEPTH_LOG2:0]   level_d;
  logic                  pop;
  logic [2:0]            req;
  logic [2:0]            we;
  logic [8:0]            wdata [3];
  logic [DEPTH_LOG2-1:0] waddr [3];
  logic [CntW-1:0]       space;
  logic [CntW-1:0]       n_wr;
  logic                  drop;

`ifdef FRAME_CRC_EN
  logic [7:0]            crc_q;

  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction
`endif

  assign pop        = (state_q == StIdle) && (level_q != '0);
  assign req        = {frame_end, pix_valid, frame_start};
  assign fifo_level = level_q;
  assign busy       = (state_q != StIdle) || (level_q != '0);

  // Entries land in priority order SOF, pixel, EOF; a same-cycle pop frees one slot.
  always_comb begin
    wdata[0] = 9'h100;
    wdata[1] = {1'b0, pix_data};
    wdata[2] = 9'h101;
    space    = CntW'(Depth) - CntW'(level_q) + CntW'(pop);
    n_wr     = '0;
    we       = '0;
    drop     = 1'b0;
    for (int k = 0; k < 3; k++) begin
      waddr[k] = wr_ptr_q + n_wr[DEPTH_LOG2-1:0];
      if (req[k]) begin
        if (n_wr < space) begin
          we[k] = 1'b1;
          n_wr  = n_wr + CntW'(1);
        end else begin
          drop = 1'b1;
        end
      end
    end
    level_d = level_q + n_wr[DEPTH_LOG2:0] - {{DEPTH_LOG2{1'b0}}, pop};
  end

  always_ff @(posedge sys_clk) begin
    for (int k = 0; k < 3; k++) begin
      if (we[k]) begin
        mem[waddr[k]] <= wdata[k];
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_q + n_wr[DEPTH_LOG2-1:0];
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      end
      level_q <= level_d;
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Byte to present and the state to resume once its handshake completes.
  always_comb begin
    byte_sel = head_q[7:0];
    follow   = StIdle;
    case (state_q)
      StHdr0: begin
        byte_sel = SYNC0;
        follow   = StHdr1;
      end
      StHdr1: begin
        byte_sel = SYNC1;
        follow   = StHdr2;
      end
      StHdr2: byte_sel = SYNC2;
`ifdef FRAME_CRC_EN
      StCrc:  byte_sel = crc_q;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q  <= StIdle;
      nxt_q    <= StIdle;
      head_q   <= '0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
`ifdef FRAME_CRC_EN
      crc_q    <= 8'h00;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (pop) begin
            head_q  <= mem[rd_ptr_q];
            state_q <= StPop;
          end
        end
        StPop: begin
          if (!head_q[8]) begin
            state_q <= StSend;
`ifdef FRAME_CRC_EN
            crc_q   <= crc8_next(crc_q, head_q[7:0]);
`endif
          end else if (head_q[7:0] == 8'h00) begin
            state_q <= StHdr0;
`ifdef FRAME_CRC_EN
            crc_q   <= 8'h00;
`endif
          end else begin
`ifdef FRAME_CRC_EN
            state_q <= StCrc;
`else
            state_q <= StIdle;
`endif
          end
        end
        // Hold off tx_start while the UART is still finishing the previous byte.
        StHdr0, StHdr1, StHdr2, StSend: begin
          tx_data <= byte_sel;
          nxt_q   <= follow;
          if (tx_finish) begin
            tx_start <= 1'b1;
            state_q  <= StWaitAck;
          end
        end
`ifdef FRAME_CRC_EN
        StCrc: begin
          tx_data <= byte_sel;
          nxt_q   <= follow;
          if (tx_finish) begin
            tx_start <= 1'b1;
            state_q  <= StWaitAck;
          end
        end
`endif
        StWaitAck: begin
          if (!tx_finish) begin
            tx_start <= 1'b0;
            state_q  <= StWaitDone;
          end
        end
        StWaitDone: begin
          if (tx_finish) begin
            state_q <= nxt_q;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_uart_packer.sv
// Directed bench for frame_uart_packer: a negedge UART responder captures every byte sent.
module tb_frame_uart_packer;

  logic       sys_clk     = 1'b0;
  logic       rst         = 1'b1;
  logic       frame_start = 1'b0;
  logic       frame_end   = 1'b0;
  logic       pix_valid   = 1'b0;
  logic [7:0] pix_data    = 8'h00;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_finish   = 1'b1;
  logic       overflow;
  logic [9:0] fifo_level;
  logic       busy;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] got   [$];
  logic [7:0] exp_q [$];
  bit         hold     = 1'b0;
  int         busy_len = 10;
  int         cnt      = 0;

  always #5 sys_clk = ~sys_clk;

  frame_uart_packer dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .frame_start(frame_start),
    .frame_end  (frame_end),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_finish  (tx_finish),
    .overflow   (overflow),
    .fifo_level (fifo_level),
    .busy       (busy)
  );

  // UART model: accepts a byte when idle and tx_start is high, then stays busy busy_len cycles.
  always @(negedge sys_clk) begin
    if (cnt > 0) cnt--;
    if (hold) begin
      tx_finish = 1'b0;
    end else if (!tx_finish) begin
      if (cnt == 0) tx_finish = 1'b1;
    end else if (tx_start === 1'b1) begin
      got.push_back(tx_data);
      tx_finish = 1'b0;
      cnt       = busy_len;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_bytes(input int n, input int limit, input string tag);
    int k = 0;
    while (got.size() < n && k < limit) begin
      @(negedge sys_clk);
      k++;
    end
    check(tag, 32'(got.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input int limit, input string tag);
    int k = 0;
    while ((busy !== 1'b0 || tx_finish !== 1'b1) && k < limit) begin
      @(negedge sys_clk);
      k++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic check_seq(input string tag);
    logic [31:0] obs;
    check({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (i < got.size()) ? {24'd0, got[i]} : 32'hFFFF_FFFF;
      check($sformatf("%s_b%0d", tag, i), obs, {24'd0, exp_q[i]});
    end
  endtask

  initial begin
    int bad;
    bit stable;

    // Reset state
    repeat (3) @(negedge sys_clk);
    rst = 1'b0;
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Single pixel latency: tx_start rises on the third edge after pix_valid is sampled
    pix_valid = 1'b1;
    pix_data  = 8'h5A;
    @(negedge sys_clk);
    pix_valid = 1'b0;
    check("lat_level1", 32'(fifo_level), 32'd1);
    @(negedge sys_clk);
    @(negedge sys_clk);
    check("lat_early", 32'(tx_start), 32'd0);
    @(negedge sys_clk);
    check("lat_start", 32'(tx_start), 32'd1);
    check("lat_data", 32'(tx_data), 32'h5A);
    wait_idle(200, "lat_idle");
    check("lat_byte", (got.size() > 0) ? {24'd0, got[0]} : 32'hFFFF_FFFF, 32'h5A);

    // Basic frame
    got.delete();
    frame_start = 1'b1;
    @(negedge sys_clk);
    frame_start = 1'b0;
    pix_valid   = 1'b1;
    pix_data    = 8'h11;
    @(negedge sys_clk);
    pix_data    = 8'h22;
    @(negedge sys_clk);
    pix_valid   = 1'b0;
    frame_end   = 1'b1;
    @(negedge sys_clk);
    frame_end   = 1'b0;
    wait_bytes(5, 1000, "frame_timeout");
    wait_idle(200, "frame_idle");
    exp_q = '{8'hFF, 8'h00, 8'hA5, 8'h11, 8'h22};
    check_seq("frame");
    check("frame_level", 32'(fifo_level), 32'd0);

    // All three strobes in one cycle
    got.delete();
    frame_start = 1'b1;
    pix_valid   = 1'b1;
    frame_end   = 1'b1;
    pix_data    = 8'h3C;
    @(negedge sys_clk);
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    frame_end   = 1'b0;
    check("tri_level", 32'(fifo_level), 32'd3);
    wait_bytes(4, 1000, "tri_timeout");
    wait_idle(200, "tri_idle");
    exp_q = '{8'hFF, 8'h00, 8'hA5, 8'h3C};
    check_seq("tri");
    check("tri_overflow", 32'(overflow), 32'd0);

    // Long UART busy after the ack: outputs frozen, nothing skipped
    got.delete();
    busy_len  = 50;
    pix_valid = 1'b1;
    pix_data  = 8'h77;
    @(negedge sys_clk);
    pix_data  = 8'h78;
    @(negedge sys_clk);
    pix_valid = 1'b0;
    wait_bytes(1, 100, "slow_first");
    @(negedge sys_clk);
    stable = 1'b1;
    repeat (46) begin
      if (tx_start !== 1'b0 || tx_data !== 8'h77) stable = 1'b0;
      @(negedge sys_clk);
    end
    check("slow_stable", 32'(stable), 32'd1);
    wait_bytes(2, 500, "slow_second");
    wait_idle(500, "slow_idle");
    exp_q = '{8'h77, 8'h78};
    check_seq("slow");
    busy_len = 2;

    // Overflow: one byte is popped into SEND before stalling, 512 more fill the FIFO
    got.delete();
    hold = 1'b1;
    repeat (2) @(negedge sys_clk);
    for (int i = 0; i < 600; i++) begin
      pix_valid = 1'b1;
      pix_data  = i[7:0];
      @(negedge sys_clk);
    end
    pix_valid = 1'b0;
    @(negedge sys_clk);
    check("ovf_level", 32'(fifo_level), 32'd512);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_no_start", 32'(tx_start), 32'd0);
    hold = 1'b0;
    wait_bytes(513, 20000, "ovf_timeout");
    wait_idle(500, "ovf_idle");
    check("ovf_count", 32'(got.size()), 32'd513);
    bad = 0;
    for (int i = 0; i < got.size(); i++) begin
      if (got[i] !== i[7:0]) bad++;
    end
    check("ovf_order", 32'(bad), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Reset while waiting for the UART to finish
    got.delete();
    busy_len  = 20;
    pix_valid = 1'b1;
    pix_data  = 8'hA1;
    @(negedge sys_clk);
    pix_data  = 8'hA2;
    @(negedge sys_clk);
    pix_valid = 1'b0;
    wait_bytes(1, 100, "mid_first");
    repeat (2) @(negedge sys_clk);
    check("mid_pre_level", 32'(fifo_level), 32'd1);
    check("mid_pre_ovf", 32'(overflow), 32'd1);
    rst = 1'b1;
    @(negedge sys_clk);
    rst = 1'b0;
    check("mid_tx_start", 32'(tx_start), 32'd0);
    check("mid_level", 32'(fifo_level), 32'd0);
    check("mid_ovf", 32'(overflow), 32'd0);
    busy_len = 4;
    wait_idle(200, "mid_uart_idle");
    got.delete();
    frame_start = 1'b1;
    @(negedge sys_clk);
    frame_start = 1'b0;
    pix_valid   = 1'b1;
    pix_data    = 8'hB7;
    @(negedge sys_clk);
    pix_valid   = 1'b0;
    frame_end   = 1'b1;
    @(negedge sys_clk);
    frame_end   = 1'b0;
    wait_bytes(4, 1000, "post_timeout");
    wait_idle(200, "post_idle");
    exp_q = '{8'hFF, 8'h00, 8'hA5, 8'hB7};
    check_seq("post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
